adex_step_scheduler: RTL and testbench

Time-multiplexes one shared AdEx update datapath across `N_NEURONS` neuron state slots. Generates the integration timestep tick from a programmable clock divider and walks the slots round-robin once per tick. For each slot it issues a start/done handshake to the datapath and writes back the new `v`/`w`. It sits between the top-level TT pin decode and the neuron datapath, and holds all per-neuron state so the datapath stays stateless.

---
 rtl/adex_sched_pkg.sv | 16 +
 rtl/adex_tick_div.sv | 25 ++
 rtl/adex_step_scheduler.sv | 159 +++++++++++++++
 tb/tb_adex_step_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adex_sched_pkg.sv
// rtl/adex_sched_pkg.sv - shared types and constants for the AdEx step scheduler
package adex_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_WRITEBACK
   } sched_state_t;

   localparam int STATE_W_DEF = 32;

   // Resting membrane potential, -65 in Q.7
   localparam int V_RESET_Q = -65 * 128;

endpackage

// File: rtl/adex_tick_div.sv
// rtl/adex_tick_div.sv - programmable integration tick divider, period div_cfg+1 clocks
module adex_tick_div (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [7:0] div_cfg,
   output logic       tick
);

   logic [7:0] cnt;

   // >= keeps the counter from running away if div_cfg is lowered mid-count
   assign tick = run && (cnt >= div_cfg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/adex_step_scheduler.sv
// rtl/adex_step_scheduler.sv - round-robin sequencer sharing one AdEx datapath across N state slots
module adex_step_scheduler
   import adex_sched_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int STATE_W   = STATE_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   input  logic [7:0]                   div_cfg,
   input  logic                         cfg_busy,
   input  logic                         soft_clear,
   input  logic                         dp_ready,
   input  logic                         dp_done,
   input  logic [STATE_W-1:0]           dp_v_next,
   input  logic [STATE_W-1:0]           dp_w_next,
   input  logic                         dp_spike,
   output logic                         dp_start,
   output logic [$clog2(N_NEURONS)-1:0] dp_sel,
   output logic [STATE_W-1:0]           dp_v,
   output logic [STATE_W-1:0]           dp_w,
   output logic [N_NEURONS-1:0]         spike_vec,
   output logic [7:0]                   spike_cnt,
   output logic                         frame_done,
   output logic                         overrun,
   output logic                         busy
);

   localparam int                  SEL_W    = $clog2(N_NEURONS);
   localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(N_NEURONS - 1);
   localparam logic [STATE_W-1:0]  V_RST    = STATE_W'(V_RESET_Q);

   sched_state_t state, state_nx;

   logic                 tick;
   logic [STATE_W-1:0]   slot_v [N_NEURONS];
   logic [STATE_W-1:0]   slot_w [N_NEURONS];
   logic [STATE_W-1:0]   cap_v, cap_w;
   logic                 cap_spike;
   logic [N_NEURONS-1:0] spike_work, spike_upd;
   logic                 frame_start, clear_now, last_slot;

   adex_tick_div u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .div_cfg (div_cfg),
      .tick    (tick)
   );

   assign clear_now = soft_clear && (state == ST_IDLE);
   assign last_slot = (dp_sel == LAST_SEL);
   assign busy      = (state != ST_IDLE);
   assign dp_v      = slot_v[dp_sel];
   assign dp_w      = slot_w[dp_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      dp_start    = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      case (state)
         // soft_clear takes priority over a tick landing in the same cycle
         ST_IDLE: begin
            if (tick && !cfg_busy && !soft_clear) begin
               frame_start = 1'b1;
               state_nx    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (dp_ready) begin
               dp_start = 1'b1;
               state_nx = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (dp_done) begin
               state_nx = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: begin
            if (last_slot) begin
               frame_done = 1'b1;
               state_nx   = ST_IDLE;
            end else begin
               state_nx = ST_ISSUE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      spike_upd         = spike_work;
      spike_upd[dp_sel] = spike_work[dp_sel] | cap_spike;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_sel     <= '0;
         cap_v      <= '0;
         cap_w      <= '0;
         cap_spike  <= 1'b0;
         spike_work <= '0;
         spike_vec  <= '0;
         spike_cnt  <= '0;
         overrun    <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            slot_v[i] <= V_RST;
            slot_w[i] <= '0;
         end
      end else begin
         if (clear_now) begin
            overrun <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
               slot_v[i] <= V_RST;
               slot_w[i] <= '0;
            end
         end else if (tick && state != ST_IDLE) begin
            overrun <= 1'b1;
         end

         if (frame_start) begin
            dp_sel     <= '0;
            spike_work <= '0;
         end

         if (state == ST_WAIT_DONE && dp_done) begin
            cap_v     <= dp_v_next;
            cap_w     <= dp_w_next;
            cap_spike <= dp_spike;
         end

         if (state == ST_WRITEBACK) begin
            slot_v[dp_sel] <= cap_v;
            slot_w[dp_sel] <= cap_w;
            spike_work     <= spike_upd;
            if (cap_spike && spike_cnt != 8'hFF) begin
               spike_cnt <= spike_cnt + 8'd1;
            end
            if (last_slot) begin
               spike_vec <= spike_upd;
            end else begin
               dp_sel <= dp_sel + SEL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_adex_step_scheduler.sv
// tb/tb_adex_step_scheduler.sv - self-checking bench for adex_step_scheduler
module tb_adex_step_scheduler;

   localparam int N = 4;
   localparam logic [31:0] VRST = 32'(-8320);

   logic          clk, rst_n, run, cfg_busy, soft_clear, dp_ready, dp_done, dp_spike;
   logic [7:0]    div_cfg;
   logic [31:0]   dp_v_next, dp_w_next;
   logic          dp_start, frame_done, overrun, busy;
   logic [1:0]    dp_sel;
   logic [31:0]   dp_v, dp_w;
   logic [N-1:0]  spike_vec;
   logic [7:0]    spike_cnt;

   adex_step_scheduler #(.N_NEURONS(N), .STATE_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .div_cfg(div_cfg), .cfg_busy(cfg_busy),
      .soft_clear(soft_clear), .dp_ready(dp_ready), .dp_done(dp_done),
      .dp_v_next(dp_v_next), .dp_w_next(dp_w_next), .dp_spike(dp_spike),
      .dp_start(dp_start), .dp_sel(dp_sel), .dp_v(dp_v), .dp_w(dp_w),
      .spike_vec(spike_vec), .spike_cnt(spike_cnt), .frame_done(frame_done),
      .overrun(overrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Reference model: slot contents, spike bookkeeping, issue order
   logic [31:0]  ref_v [N];
   logic [31:0]  ref_w [N];
   logic [N-1:0] frame_spk;
   int           model_cnt;
   bit           model_active;
   int           exp_sel;

   // Datapath stand-in configuration
   int           lat;
   bit           rand_mode;
   logic [31:0]  vinc, winc;
   logic [N-1:0] spk_mask;

   bit pend;
   int due, rcyc, psel;

   initial begin
      dp_done = 1'b0; dp_v_next = '0; dp_w_next = '0; dp_spike = 1'b0;
      pend = 0; rcyc = 0; model_active = 0; model_cnt = 0; frame_spk = '0;
      for (int i = 0; i < N; i++) begin ref_v[i] = VRST; ref_w[i] = '0; end
      forever begin
         @(posedge clk);
         #2;
         rcyc++;
         dp_done = 1'b0;
         if (!rst_n) begin
            pend = 0; model_active = 0; model_cnt = 0; frame_spk = '0;
            for (int i = 0; i < N; i++) begin ref_v[i] = VRST; ref_w[i] = '0; end
         end else begin
            if (soft_clear && !model_active) begin
               for (int i = 0; i < N; i++) begin ref_v[i] = VRST; ref_w[i] = '0; end
            end
            if (pend && rcyc == due) begin
               dp_done = 1'b1;
               if (rand_mode) begin
                  dp_v_next = $urandom;
                  dp_w_next = $urandom;
                  dp_spike  = 1'($urandom_range(0, 1));
               end else begin
                  dp_v_next = ref_v[psel] + vinc;
                  dp_w_next = ref_w[psel] + winc;
                  dp_spike  = spk_mask[psel];
               end
               ref_v[psel] = dp_v_next;
               ref_w[psel] = dp_w_next;
               if (dp_spike) begin
                  frame_spk[psel] = 1'b1;
                  if (model_cnt < 255) model_cnt++;
               end
               if (psel == N - 1) model_active = 0;
               pend = 0;
            end
            if (dp_start) begin
               if (dp_sel == 2'd0) begin frame_spk = '0; model_active = 1; end
               pend = 1;
               psel = int'(dp_sel);
               due  = rcyc + (rand_mode ? int'($urandom_range(1, 4)) : lat);
            end
         end
      end
   end

   bit           chk_pend;
   logic [N-1:0] exp_vec;

   initial begin
      chk_pend = 0; exp_sel = 0; exp_vec = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk_pend = 0;
            exp_sel  = 0;
         end else begin
            if (chk_pend) begin
               check("spike_vec_frame", spike_vec, exp_vec);
               check("spike_cnt_frame", spike_cnt, model_cnt);
               chk_pend = 0;
            end
            if (dp_start) begin
               check("issue_order", dp_sel, exp_sel);
               check("dp_v_slot", dp_v, ref_v[dp_sel]);
               check("dp_w_slot", dp_w, ref_w[dp_sel]);
               exp_sel = (exp_sel + 1) % N;
            end
            if (frame_done) begin
               exp_vec  = frame_spk;
               chk_pend = 1;
            end
         end
      end
   end

   task automatic wait_tick(output int t, input int budget);
      bit found = 0;
      t = -1;
      for (int i = 0; i < budget && !found; i++) begin
         adv(); smp();
         if (dut.u_div.tick) begin found = 1; t = cyc; end
      end
      check("tick_seen", found, 1);
   endtask

   task automatic wait_frame_done(input int budget);
      bit found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         adv(); smp();
         if (frame_done) found = 1;
      end
      check("frame_done_seen", found, 1);
   endtask

   typedef struct {
      logic [7:0] div;
      logic       run;
      int         ncyc;
      int         exp_ticks;
   } div_vec_t;

   div_vec_t dv [5];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, fd, n_st, tk, frames;
      bit ok, found;
      int st_cyc[$];
      int st_sel[$];

      rst_n = 0; run = 0; div_cfg = 0; cfg_busy = 0; soft_clear = 0; dp_ready = 1;
      lat = 2; vinc = 128; winc = 5; spk_mask = '0; rand_mode = 0;

      dv[0] = '{div: 8'd3, run: 1'b1, ncyc: 12, exp_ticks: 3};
      dv[1] = '{div: 8'd0, run: 1'b1, ncyc: 5,  exp_ticks: 5};
      dv[2] = '{div: 8'd7, run: 1'b1, ncyc: 20, exp_ticks: 2};
      dv[3] = '{div: 8'd0, run: 1'b0, ncyc: 10, exp_ticks: 0};
      dv[4] = '{div: 8'd4, run: 1'b1, ncyc: 9,  exp_ticks: 1};

      repeat (3) adv();
      smp();
      check("rst_dp_start", dp_start, 0);
      check("rst_dp_sel", dp_sel, 0);
      check("rst_dp_v", dp_v, VRST);
      check("rst_dp_w", dp_w, 0);
      check("rst_spike_vec", spike_vec, 0);
      check("rst_spike_cnt", spike_cnt, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      adv(); rst_n = 1;

      // Divider table, with cfg_busy holding off any frame
      cfg_busy = 1;
      foreach (dv[k]) begin
         adv(); run = 0; div_cfg = dv[k].div; smp();
         tk = 0; n_st = 0; ok = 1;
         for (int i = 0; i < dv[k].ncyc; i++) begin
            adv(); run = dv[k].run; smp();
            if (dut.u_div.tick) tk++;
            if (dp_start) n_st++;
            if (dut.u_div.tick !== (dv[k].run && (i % (dv[k].div + 1)) == dv[k].div)) ok = 0;
         end
         check("div_ticks", tk, dv[k].exp_ticks);
         check("div_no_start", n_st, 0);
         check("div_spacing", ok, 1);
      end
      check("div_busy", busy, 0);
      adv(); run = 0; cfg_busy = 0;

      // Frame sequencing: L=2, v+128, spike on slot 2
      div_cfg = 31; spk_mask = 4'b0100;
      adv(); run = 1;
      wait_tick(t, 40);
      fd = -1;
      for (int i = 0; i < 18; i++) begin
         adv(); smp();
         if (dp_start) begin st_cyc.push_back(cyc - t); st_sel.push_back(int'(dp_sel)); end
         if (frame_done) fd = cyc - t;
      end
      adv(); run = 0; smp();
      check("frm_starts", st_cyc.size(), 4);
      for (int k = 0; k < st_cyc.size() && k < 4; k++) begin
         check("frm_start_cyc", st_cyc[k], 1 + 4 * k);
         check("frm_sel", st_sel[k], k);
      end
      check("frm_done_cyc", fd, 16);
      check("frm_spike_vec", spike_vec, 4'b0100);
      check("frm_spike_cnt", spike_cnt, 1);
      check("frm_slot3_v", dp_v, 32'(-8192));
      check("frm_slot3_w", dp_w, 5);
      check("frm_idle", busy, 0);
      check("frm_no_overrun", overrun, 0);

      // Backpressure: ready low for the first 5 ISSUE cycles
      dp_ready = 0;
      adv(); run = 1;
      wait_tick(t, 40);
      ok = 1;
      for (int i = 1; i <= 5; i++) begin
         adv(); smp();
         if (dp_start !== 1'b0 || dp_v !== 32'(-8192) || busy !== 1'b1) ok = 0;
      end
      check("bp_hold", ok, 1);
      adv(); dp_ready = 1; smp();
      check("bp_start", dp_start, 1);
      check("bp_delay", cyc - t, 6);
      check("bp_sel", dp_sel, 0);
      adv(); smp();
      check("bp_single", dp_start, 0);
      wait_frame_done(40);
      adv(); run = 0;

      // soft_clear in IDLE restores slots
      adv(); soft_clear = 1; smp();
      adv(); soft_clear = 0; smp();
      check("sc_slot_v", dp_v, VRST);
      check("sc_slot_w", dp_w, 0);

      // Overrun: tick period 4 against a 16-cycle frame
      div_cfg = 3;
      adv(); run = 1;
      wait_tick(t, 10);
      n_st = 0; fd = -1;
      for (int i = 0; i < 30 && fd < 0; i++) begin
         adv(); smp();
         if (cyc == t + 4) check("ovr_before", overrun, 0);
         if (cyc == t + 5) check("ovr_set", overrun, 1);
         if (dp_start) n_st++;
         if (frame_done) fd = cyc - t;
      end
      adv(); run = 0; smp();
      check("ovr_writebacks", n_st, 4);
      check("ovr_frame_done", fd, 16);
      check("ovr_sticky", overrun, 1);

      // soft_clear landing on the starting tick
      adv(); run = 1; smp();
      adv(); smp();
      adv(); smp();
      adv(); soft_clear = 1; smp();
      check("sc_tick_align", dut.u_div.tick, 1);
      adv(); soft_clear = 0; run = 0; smp();
      check("sc_no_frame", busy, 0);
      check("sc_ovr_clr", overrun, 0);
      check("sc_no_start", dp_start, 0);

      // Reset during WAIT_DONE of slot 1
      adv(); run = 1;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         adv(); smp();
         if (dp_start && dp_sel == 2'd1) found = 1;
      end
      check("rst_reach_slot1", found, 1);
      adv(); smp();
      check("rst_in_wait", busy, 1);
      adv(); rst_n = 0; #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_start", dp_start, 0);
      check("rstmid_sel", dp_sel, 0);
      check("rstmid_v", dp_v, VRST);
      check("rstmid_cnt", spike_cnt, 0);
      smp();
      adv(); rst_n = 1; run = 0; smp();
      adv(); smp();
      check("rst_no_wb_v", dp_v, VRST);
      check("rst_no_wb_w", dp_w, 0);

      // Randomized frames: random latency, values, spikes, ready and cfg_busy
      rand_mode = 1; div_cfg = 60;
      adv(); run = 1;
      frames = 0;
      for (int i = 0; i < 4000 && frames < 8; i++) begin
         adv();
         dp_ready = ($urandom_range(0, 3) != 0);
         cfg_busy = ($urandom_range(0, 7) == 0);
         smp();
         if (frame_done) frames++;
      end
      adv(); run = 0; cfg_busy = 0; dp_ready = 1; rand_mode = 0; smp();
      check("rand_frames", frames, 8);

      // Spike counter saturation
      spk_mask = '1; lat = 1; div_cfg = 15;
      adv(); run = 1;
      frames = 0;
      for (int i = 0; i < 2000 && frames < 70; i++) begin
         adv(); smp();
         if (frame_done) frames++;
      end
      adv(); run = 0; smp();
      adv(); smp();
      check("sat_frames", frames, 70);
      check("spike_cnt_sat", spike_cnt, 255);
      check("sat_spike_vec", spike_vec, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
